// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between a CPU port (priority) and
// a read-only video port, with a starvation guard and tagged read return.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_LIM = 4,
  localparam int CNT_W     = $clog2(STARVE_LIM + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_rd_owner,
  output logic [CNT_W-1:0]  dbg_starve_cnt
);

  // Handshake: a requester holds req with stable address/data until it sees gnt
  // in the same cycle; gnt means the RAM access is issued that cycle. Read data
  // returns exactly one cycle later, qualified by a one-cycle rvalid pulse.

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2
  } owner_t;

  owner_t             rd_owner, owner_nxt;
  logic [CNT_W-1:0]   starve_cnt, starve_nxt;
  logic [DATA_W-1:0]  cpu_rdata_q, vid_rdata_q;
  logic               force_vid;

  assign force_vid = vid_req && (starve_cnt >= CNT_W'(STARVE_LIM));
  // Grants are masked while reset is low so nothing reaches the RAM.
  assign vid_gnt   = reset && vid_req && (!cpu_req || force_vid);
  assign cpu_gnt   = reset && cpu_req && !vid_gnt;

  assign mem_we    = cpu_gnt && cpu_we;
  assign mem_addr  = cpu_gnt ? cpu_addr : (vid_gnt ? vid_addr : '0);
  assign mem_wdata = cpu_gnt ? cpu_wdata : '0;

  always_comb begin
    starve_nxt = starve_cnt;
    owner_nxt  = OWN_NONE;
    if (vid_gnt || !vid_req) begin
      starve_nxt = '0;
    end else if (cpu_gnt && (starve_cnt < CNT_W'(STARVE_LIM))) begin
      starve_nxt = starve_cnt + 1'b1;
    end
    if (cpu_gnt && !cpu_we) begin
      owner_nxt = OWN_CPU;
    end else if (vid_gnt) begin
      owner_nxt = OWN_VID;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt  <= '0;
      rd_owner    <= OWN_NONE;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      rd_owner   <= owner_nxt;
      if (rd_owner == OWN_CPU) cpu_rdata_q <= mem_rdata;
      if (rd_owner == OWN_VID) vid_rdata_q <= mem_rdata;
    end
  end

  // RAM data arrives in the cycle the tag is live; the register holds it after.
  assign cpu_rvalid = (rd_owner == OWN_CPU);
  assign vid_rvalid = (rd_owner == OWN_VID);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign vid_rdata  = vid_rvalid ? mem_rdata : vid_rdata_q;

  assign dbg_rd_owner   = rd_owner;
  assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table-driven grant vectors, a RAM
// model, and a read-return scoreboard fed from a shadow memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, vid_req;
  logic [15:0] cpu_addr, cpu_wdata, vid_addr;
  logic        cpu_gnt, cpu_rvalid, vid_gnt, vid_rvalid;
  logic [15:0] cpu_rdata, vid_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [1:0]  dbg_rd_owner;
  logic [2:0]  dbg_starve_cnt;

  int errors = 0;
  int checks = 0;

  bit [15:0] ram    [0:65535];
  bit [15:0] shadow [0:65535];

  logic [15:0] cpu_exp_q[$];
  logic [15:0] vid_exp_q[$];
  logic        m_cpu_pend, m_vid_pend;
  logic [15:0] m_cpu_last, m_vid_last;

  typedef struct {
    logic        cr;
    logic        cw;
    logic [15:0] ca;
    logic [15:0] cd;
    logic        vr;
    logic [15:0] va;
    logic        eg_c;
    logic        eg_v;
  } vec_t;

  vec_t vecs[$];

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIM(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_rd_owner(dbg_rd_owner), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // Clock and write-first synchronous RAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= mem_we ? mem_wdata : ram[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cpu_pend = 1'b0;
    m_vid_pend = 1'b0;
    m_cpu_last = '0;
    m_vid_last = '0;
    cpu_exp_q.delete();
    vid_exp_q.delete();
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 1'b0; vid_addr = '0;
  endtask

  // One clock cycle: drive, check grants and returns at negedge, update model.
  task automatic cycle(input logic cr, input logic cw, input logic [15:0] ca,
                       input logic [15:0] cd, input logic vr, input logic [15:0] va,
                       input logic eg_c, input logic eg_v, input string nm);
    logic [15:0] e_addr;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    vid_req = vr; vid_addr = va;
    @(negedge clk);
    e_addr = eg_c ? ca : (eg_v ? va : 16'h0000);
    chk({nm, ".cpu_gnt"}, cpu_gnt, eg_c);
    chk({nm, ".vid_gnt"}, vid_gnt, eg_v);
    chk({nm, ".mem_we"}, mem_we, eg_c && cw);
    chk({nm, ".mem_addr"}, mem_addr, e_addr);
    if (eg_c) chk({nm, ".mem_wdata"}, mem_wdata, cd);
    chk({nm, ".cpu_rvalid"}, cpu_rvalid, m_cpu_pend);
    chk({nm, ".vid_rvalid"}, vid_rvalid, m_vid_pend);
    if (m_cpu_pend) m_cpu_last = cpu_exp_q.pop_front();
    if (m_vid_pend) m_vid_last = vid_exp_q.pop_front();
    chk({nm, ".cpu_rdata"}, cpu_rdata, m_cpu_last);
    chk({nm, ".vid_rdata"}, vid_rdata, m_vid_last);
    m_cpu_pend = eg_c && !cw;
    m_vid_pend = eg_v;
    if (m_cpu_pend) cpu_exp_q.push_back(shadow[ca]);
    if (m_vid_pend) vid_exp_q.push_back(shadow[va]);
    if (eg_c && cw) shadow[ca] = cd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] a;
    // Vector table: CPU writes, contended stream, video burst, flush
    for (int i = 0; i < 4; i++)
      vecs.push_back('{1'b1, 1'b1, 16'(16'h0100 + i), 16'($urandom_range(0, 65535)),
                       1'b0, 16'h0000, 1'b1, 1'b0});
    for (int i = 0; i < 15; i++)
      vecs.push_back('{1'b1, 1'b0, 16'(16'h0100 + $urandom_range(0, 3)), 16'h0000,
                       1'b1, 16'(16'h0100 + $urandom_range(0, 15)),
                       (i % 5) != 4, (i % 5) == 4});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'(16'h0100 + i),
                       1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0});

    // Reset held with both requesting
    reset = 1'b0;
    model_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0004; cpu_wdata = '0;
    vid_req = 1'b1; vid_addr = 16'h0008;
    @(negedge clk);
    chk("rst.cpu_gnt", cpu_gnt, 1'b0);
    chk("rst.vid_gnt", vid_gnt, 1'b0);
    chk("rst.mem_we", mem_we, 1'b0);
    chk("rst.mem_addr", mem_addr, 16'h0000);
    chk("rst.cpu_rvalid", cpu_rvalid, 1'b0);
    chk("rst.vid_rvalid", vid_rvalid, 1'b0);
    chk("rst.cpu_rdata", cpu_rdata, 16'h0000);
    chk("rst.vid_rdata", vid_rdata, 16'h0000);
    chk("rst.rd_owner", dbg_rd_owner, 2'd0);
    chk("rst.starve", dbg_starve_cnt, 3'd0);
    reset = 1'b1;
    #1;
    chk("rel.cpu_gnt", cpu_gnt, 1'b1);
    chk("rel.vid_gnt", vid_gnt, 1'b0);
    chk("rel.mem_addr", mem_addr, 16'h0004);
    idle_inputs();
    @(posedge clk);
    #1;

    // CPU write then read back
    cycle(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 1'b1, 1'b0, "t2.wr");
    cycle(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, "t2.rd");
    chk("t2.rdata_const", m_cpu_pend ? cpu_exp_q[0] : 16'h0000, 16'hBEEF);
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, "t2.ret");

    foreach (vecs[k])
      cycle(vecs[k].cr, vecs[k].cw, vecs[k].ca, vecs[k].cd, vecs[k].vr, vecs[k].va,
            vecs[k].eg_c, vecs[k].eg_v, $sformatf("vec%0d", k));

    // Reset pulsed the cycle after a granted read
    cycle(1'b1, 1'b0, 16'h0101, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, "t5.rd");
    idle_inputs();
    reset = 1'b0;
    #2;
    chk("t5.cpu_rvalid", cpu_rvalid, 1'b0);
    chk("t5.rd_owner", dbg_rd_owner, 2'd0);
    chk("t5.cpu_rdata", cpu_rdata, 16'h0000);
    #1;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, "t5.idle0");
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, "t5.idle1");

    // CPU write arriving when the video port is owed a slot
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom_range(16'h0100, 16'h0103));
      cycle(1'b1, 1'b0, a, 16'h0000, 1'b1, 16'h0102, 1'b1, 1'b0, $sformatf("t6.c%0d", i));
    end
    chk("t6.starve", dbg_starve_cnt, 3'd4);
    cycle(1'b1, 1'b1, 16'h0020, 16'h1234, 1'b1, 16'h0103, 1'b0, 1'b1, "t6.vwin");
    cycle(1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, "t6.wr");
    cycle(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, "t6.rd");
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, "t6.ret");
    chk("t6.rdback", cpu_rdata, 16'h1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
